l1_readout_stream: RTL and testbench
====================================

# l1_readout_stream

Drains the 32x32 max-pooled layer-1 result memory (csel 3'b011) after the convolution engine finishes. It streams the 1024 words in raster order over a valid/ready interface to the next consumer. While streaming it tracks the maximum value and its index. It sits directly downstream of the conv/pool engine and shares the same layer-memory read port style (crd/caddr_rd/cdata_rd/csel).

## Interface
- WORDS, 1024, number of layer-1 words to read (addresses 0..WORDS-1)
- ADDR_W, 10, read address width
- DATA_W, 20, data width
- FIFO_DEPTH, 4, output buffer depth (power of two, >=2)
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a readout; ignored while busy=1
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last word has been accepted downstream
- crd  out  1  memory read strobe
- caddr_rd  out  ADDR_W  memory read address
- cdata_rd  in  DATA_W  memory read data
- csel  out  3  memory select: 3'b011 while busy, 3'b000 otherwise
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  stream word, equal to FIFO head
- out_last  out  1  high with out_valid on the word from address WORDS-1
- max_val  out  DATA_W  running maximum, unsigned compare
- max_idx  out  ADDR_W  address of max_val

## Operation
- Reset: busy=0, done=0, crd=0, caddr_rd=0, csel=000, out_valid=0, out_data=0, out_last=0, max_val=0, max_idx=0. FSM goes to IDLE, FIFO is emptied, in-flight flag is cleared.
- FSM states:
  - IDLE: on start, go to READ; set busy=1, set csel=011, clear max_val/max_idx, set next read address to 0.
  - READ: issue reads (see credit rule below). After the read of address WORDS-1 is issued, go to DRAIN.
  - DRAIN: no reads are issued. When the FIFO is empty and no read is in flight, go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0, csel=000, then go to IDLE.
- Read issue:
  - In READ, crd=1 and caddr_rd=next address in a cycle only if (FIFO occupancy + in-flight) < FIFO_DEPTH.
  - Otherwise crd=0, and caddr_rd holds its last value.
  - At most one read per cycle; the address increments by 1 per issued read, with no gaps or reordering.
- Read return: data for a read issued (registered) at edge N is valid on cdata_rd and is captured into the FIFO at edge N+1. The in-flight flag covers exactly that one cycle.
- Capturing a word: on each captured word, if cdata_rd > max_val (unsigned, strict), update max_val and max_idx to that word and its address. Ties keep the earlier index. max_val and max_idx are final and stable once done pulses, and hold until the next accepted start.
- FIFO:
  - Push on capture, pop when out_valid && out_ready.
  - Simultaneous push and pop when full or empty is legal: occupancy is unchanged, and on empty the pushed word becomes visible the next cycle (no combinational bypass).
  - Overflow is impossible by the credit rule.
  - out_last is stored per entry.
- start asserted while busy=1 or in DONE is ignored. An asserted reset mid-stream aborts immediately to reset values; words in flight are discarded.

## Timing
- Start-to-first crd: 1 cycle (start at edge S, crd=1 after edge S+1).
- First out_valid: 2 edges after the first read is issued.
- Full throughput with out_ready held high: one word per cycle, and 1024 words take 1024 consecutive out_valid cycles.
- Total from start to done with out_ready=1: WORDS+4 cycles (±0; this is checked exactly).
- Backpressure: out_data/out_last stay stable while out_valid=1 and out_ready=0. Reads stop once FIFO plus in-flight reaches FIFO_DEPTH, and resume the cycle after a pop frees a slot.
- done pulses the cycle after the pop of the out_last word, with no further reads issued.

## Test plan
- Ramp: mem[i]=i, out_ready=1, single start. Required: 1024 words 0..1023 in order; out_last only on 1023; max_val=1023, max_idx=1023; done exactly WORDS+4 cycles after start.
- Max with ties: mem all 5 except mem[37]=mem[900]=20'h7FFFF. Required: max_val=20'h7FFFF, max_idx=37.
- Backpressure: out_ready random 30% duty. Required: identical data order; never more than FIFO_DEPTH outstanding (occupancy + in-flight ≤ 4); out_data stable during stalls.
- Stall-then-release: out_ready=0 for 50 cycles after start. Required: exactly 4 reads issued, then crd=0; on release, streaming resumes with address 4.
- Spurious start: pulse start at word 500. Required: no effect; a second full readout after done reproduces the same stream.
- Reset mid-stream: assert reset at word 300. Required: all outputs return to reset values that cycle (asynchronous); a new start streams from address 0.

Source files
------------

// File: rtl/l1_readout_stream.sv
`default_nettype none
// ============================================================================
// Module   : l1_readout_stream
// Brief    : Drains the pooled layer-1 memory in raster order over a
//            valid/ready stream while tracking the maximum word and its index.
// Revision : 1.0 - initial release
// ============================================================================
module l1_readout_stream #(
  parameter int WORDS      = 1024,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic [2:0]        csel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_idx
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]        CSEL_L1   = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                crd_q, crd_d;
  logic [ADDR_W-1:0]   caddr_q, caddr_d;
  logic [ADDR_W-1:0]   next_addr_q, next_addr_d;
  logic [2:0]          csel_q, csel_d;
  logic [DATA_W-1:0]   max_val_q, max_val_d;
  logic [ADDR_W-1:0]   max_idx_q, max_idx_d;
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q, fifo_last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic                push;
  logic                pop;

  always_comb begin
    state_d     = state_q;
    crd_d       = 1'b0;
    caddr_d     = caddr_q;
    next_addr_d = next_addr_q;
    max_val_d   = max_val_q;
    max_idx_d   = max_idx_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    // A read registered last edge returns now; caddr_q still holds its address.
    push = crd_q;
    pop  = out_valid_q && out_ready;

    if (push) begin
      fifo_data_d[wr_ptr_q] = cdata_rd;
      fifo_last_d[wr_ptr_q] = (caddr_q == LAST_ADDR);
      wr_ptr_d              = wr_ptr_q + 1'b1;
      if (cdata_rd > max_val_q) begin
        max_val_d = cdata_rd;
        max_idx_d = caddr_q;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    // Only words already held before this edge are shown; a fresh push waits a cycle.
    out_valid_d = (count_q - CNT_W'(pop)) != '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_READ;
          next_addr_d = '0;
          max_val_d   = '0;
          max_idx_d   = '0;
        end
      end
      S_READ: begin
        if ((count_q + CNT_W'(crd_q)) < DEPTH_C) begin
          crd_d       = 1'b1;
          caddr_d     = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          if (next_addr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0 && !crd_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    csel_d = busy_d ? CSEL_L1 : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      crd_q       <= 1'b0;
      caddr_q     <= '0;
      next_addr_q <= '0;
      csel_q      <= 3'b000;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      crd_q       <= crd_d;
      caddr_q     <= caddr_d;
      next_addr_q <= next_addr_d;
      csel_q      <= csel_d;
      max_val_q   <= max_val_d;
      max_idx_q   <= max_idx_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign crd       = crd_q;
  assign caddr_rd  = caddr_q;
  assign csel      = csel_q;
  assign out_valid = out_valid_q;
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_last  = out_valid_q & fifo_last_q[rd_ptr_q];
  assign max_val   = max_val_q;
  assign max_idx   = max_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_readout_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_readout_stream
// Brief    : Scoreboard bench for l1_readout_stream with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_readout_stream;

  localparam int WORDS      = 1024;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 20;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, crd, out_valid, out_last;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] caddr_rd, max_idx;
  logic [DATA_W-1:0] cdata_rd, out_data, max_val;
  logic [2:0]        csel;

  logic [DATA_W-1:0] mem [WORDS];
  assign cdata_rd = mem[caddr_rd];

  always #5 clk = ~clk;

  l1_readout_stream #(
    .WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .max_val(max_val), .max_idx(max_idx)
  );

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int s_cyc = 0;
  exp_t sb_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] first_q[$];
  int exp_addr = 0, issued = 0, popped = 0, valid_cycles = 0;
  int first_crd_cyc = -1, first_valid_cyc = -1, last_valid_cyc = -1;
  int done_cyc = -1, done_pulses = 0, last_issue_addr = -1;
  bit rand_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic prev_last = 1'b0;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Samples at the falling edge, then advances past the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (crd === 1'b1) begin
      checks++;
      if (exp_addr >= WORDS || caddr_rd !== ADDR_W'(exp_addr)) begin
        errors++;
        $display("FAIL rd_addr: got %0d expected %0d", caddr_rd, exp_addr);
      end
      if (exp_addr < WORDS) sb_q.push_back({exp_addr == WORDS - 1, mem[exp_addr]});
      if (first_crd_cyc < 0) first_crd_cyc = cyc;
      last_issue_addr = int'(caddr_rd);
      exp_addr++;
      issued++;
    end
    checks++;
    if (issued - popped > FIFO_DEPTH) begin
      errors++;
      $display("FAIL outstanding: got %0d expected <= %0d", issued - popped, FIFO_DEPTH);
    end
    if (prev_stall) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
        errors++;
        $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                 out_valid, out_data, out_last, prev_data, prev_last);
      end
    end
    if (out_valid === 1'b1) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
    end
    if (out_valid === 1'b1 && out_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL stream_word: got %h with nothing expected", out_data);
      end else begin
        e = sb_q.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL stream_word: got last=%b data=%h expected last=%b data=%h",
                   out_last, out_data, e.last, e.data);
        end
      end
      got_q.push_back(out_data);
      popped++;
    end
    prev_stall = (out_valid === 1'b1) && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (done === 1'b1) begin
      done_pulses++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic arm();
    sb_q.delete();
    got_q.delete();
    exp_addr = 0; issued = 0; popped = 0; valid_cycles = 0;
    first_crd_cyc = -1; first_valid_cyc = -1; last_valid_cyc = -1;
    done_cyc = -1; done_pulses = 0; last_issue_addr = -1;
    prev_stall = 1'b0;
  endtask

  task automatic start_readout();
    arm();
    start = 1'b1;
    tick();
    s_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cyc >= 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, crd, out_valid, out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, crd, out_valid, out_last});
    end
    checks++;
    if (caddr_rd !== '0 || csel !== 3'b000) begin
      errors++;
      $display("FAIL reset_addr_csel: got %0d/%b expected 0/000", caddr_rd, csel);
    end
    checks++;
    if (out_data !== '0 || max_val !== '0 || max_idx !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%0d expected 0/0/0", out_data, max_val, max_idx);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ramp();
    bit to;
    for (int i = 0; i < WORDS; i++) mem[i] = DATA_W'(i);
    out_ready = 1'b1;
    start_readout();
    checks++;
    if (busy !== 1'b1 || csel !== 3'b011) begin
      errors++;
      $display("FAIL ramp_busy: got busy=%b csel=%b expected 1/011", busy, csel);
    end
    wait_done(3000, to);
    checks++;
    if (to) begin errors++; $display("FAIL ramp_timeout: got no done expected done"); end
    checks++;
    if (first_crd_cyc != s_cyc + 2) begin
      errors++; $display("FAIL ramp_first_crd: got %0d expected %0d", first_crd_cyc - s_cyc - 1, 1);
    end
    checks++;
    if (first_valid_cyc != s_cyc + 4) begin
      errors++; $display("FAIL ramp_first_valid: got %0d expected %0d", first_valid_cyc - s_cyc - 1, 3);
    end
    checks++;
    if (valid_cycles != WORDS || last_valid_cyc - first_valid_cyc != WORDS - 1) begin
      errors++; $display("FAIL ramp_throughput: got %0d valid over %0d cycles expected %0d",
                         valid_cycles, last_valid_cyc - first_valid_cyc + 1, WORDS);
    end
    checks++;
    if (done_cyc - s_cyc - 1 != WORDS + 4) begin
      errors++; $display("FAIL ramp_latency: got %0d expected %0d", done_cyc - s_cyc - 1, WORDS + 4);
    end
    checks++;
    if (popped != WORDS || issued != WORDS) begin
      errors++; $display("FAIL ramp_count: got popped=%0d issued=%0d expected %0d", popped, issued, WORDS);
    end
    checks++;
    if (max_val !== 20'd1023 || max_idx !== 10'd1023) begin
      errors++; $display("FAIL ramp_max: got %h@%0d expected 3ff@1023", max_val, max_idx);
    end
    repeat (2) tick();
    checks++;
    if (done_pulses != 1 || done !== 1'b0 || busy !== 1'b0 || csel !== 3'b000) begin
      errors++; $display("FAIL ramp_done_pulse: got pulses=%0d busy=%b csel=%b expected 1/0/000",
                         done_pulses, busy, csel);
    end
  endtask

  task automatic test_max_ties();
    bit to;
    for (int i = 0; i < WORDS; i++) mem[i] = 20'd5;
    mem[37]  = 20'h7FFFF;
    mem[900] = 20'h7FFFF;
    out_ready = 1'b1;
    start_readout();
    wait_done(3000, to);
    checks++;
    if (to) begin errors++; $display("FAIL ties_timeout: got no done expected done"); end
    repeat (3) tick();
    checks++;
    if (max_val !== 20'h7FFFF || max_idx !== 10'd37) begin
      errors++; $display("FAIL ties_max: got %h@%0d expected 7ffff@37", max_val, max_idx);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [DATA_W-1:0] mx;
    int mi;
    mx = '0;
    mi = 0;
    for (int i = 0; i < WORDS; i++) begin
      mem[i] = DATA_W'($urandom);
      if (mem[i] > mx) begin mx = mem[i]; mi = i; end
    end
    rand_ready = 1'b1;
    out_ready = 1'b0;
    start_readout();
    wait_done(12000, to);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (to) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
    checks++;
    if (popped != WORDS || sb_q.size() != 0) begin
      errors++; $display("FAIL bp_count: got popped=%0d left=%0d expected %0d/0", popped, sb_q.size(), WORDS);
    end
    checks++;
    if (max_val !== mx || max_idx !== ADDR_W'(mi)) begin
      errors++; $display("FAIL bp_max: got %h@%0d expected %h@%0d", max_val, max_idx, mx, mi);
    end
  endtask

  task automatic test_stall_release();
    bit to;
    out_ready = 1'b0;
    start_readout();
    repeat (50) tick();
    checks++;
    if (issued != FIFO_DEPTH || crd !== 1'b0) begin
      errors++; $display("FAIL stall_reads: got %0d crd=%b expected %0d crd=0", issued, crd, FIFO_DEPTH);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== mem[0]) begin
      errors++; $display("FAIL stall_head: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, mem[0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && issued < FIFO_DEPTH + 1; i++) tick();
    checks++;
    if (last_issue_addr != FIFO_DEPTH) begin
      errors++; $display("FAIL stall_resume: got %0d expected %0d", last_issue_addr, FIFO_DEPTH);
    end
    wait_done(3000, to);
    checks++;
    if (to || popped != WORDS) begin
      errors++; $display("FAIL stall_finish: got popped=%0d expected %0d", popped, WORDS);
    end
  endtask

  task automatic test_spurious_start();
    bit to;
    int diffs;
    out_ready = 1'b1;
    start_readout();
    for (int i = 0; i < 2000 && popped < 500; i++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3000, to);
    checks++;
    if (to || done_cyc - s_cyc - 1 != WORDS + 4 || popped != WORDS) begin
      errors++; $display("FAIL spurious_run: got latency=%0d popped=%0d expected %0d/%0d",
                         done_cyc - s_cyc - 1, popped, WORDS + 4, WORDS);
    end
    first_q = got_q;
    repeat (2) tick();
    start_readout();
    wait_done(3000, to);
    diffs = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (i >= got_q.size() || i >= first_q.size() || got_q[i] !== first_q[i]) diffs++;
    end
    checks++;
    if (to || diffs != 0) begin
      errors++; $display("FAIL spurious_repeat: got %0d differing words expected 0", diffs);
    end
  endtask

  task automatic test_reset_midstream();
    bit to;
    for (int i = 0; i < WORDS; i++) mem[i] = DATA_W'(i);
    out_ready = 1'b1;
    start_readout();
    for (int i = 0; i < 2000 && popped < 300; i++) tick();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, crd, out_valid, out_last} !== 5'b0 || csel !== 3'b000 || caddr_rd !== '0) begin
      errors++; $display("FAIL midreset_ctrl: got %b csel=%b addr=%0d expected 00000/000/0",
                         {busy, done, crd, out_valid, out_last}, csel, caddr_rd);
    end
    checks++;
    if (out_data !== '0 || max_val !== '0 || max_idx !== '0) begin
      errors++; $display("FAIL midreset_data: got %h/%h/%0d expected 0/0/0", out_data, max_val, max_idx);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    start_readout();
    wait_done(3000, to);
    checks++;
    if (to || popped != WORDS || got_q.size() == 0 || got_q[0] !== '0) begin
      errors++; $display("FAIL midreset_restart: got popped=%0d expected %0d from address 0", popped, WORDS);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_max_ties();
    test_backpressure();
    test_stall_release();
    test_spurious_start();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
